// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU pipeline and the word-addressed data memory.
// Checks alignment and range, does read-modify-write for sub-word stores, and extends loads.
module mem_access_unit #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h10010000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpuAddr,
  input  logic [31:0]           cpuWriteData,
  input  logic                  cpuMemRead,
  input  logic                  cpuMemWrite,
  input  logic [1:0]            cpuSize,
  input  logic                  cpuSignExt,
  output logic [31:0]           cpuReadData,
  output logic                  busy,
  output logic                  done,
  output logic                  addrError,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWriteData,
  output logic                  memRead,
  output logic                  memWrite,
  input  logic [31:0]           memReadData
);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           word_q, word_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] offset;
  logic [1:0]  req_lane;
  logic        req_err;

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: return {{24{sext & b[7]}}, b};
      SIZE_HALF: return {{16{sext & h[15]}}, h};
      default:   return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (size == SIZE_BYTE) m[{lane, 3'b000} +: 8] = d[7:0];
    else                   m[{lane[1], 4'b0000} +: 16] = d[15:0];
    return m;
  endfunction

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign offset   = cpuAddr - BASE_ADDR;
  assign req_lane = offset[1:0];
  assign req_err  = (cpuMemRead && cpuMemWrite)
                 || (cpuSize == 2'b11)
                 || (cpuSize == SIZE_HALF && req_lane[0])
                 || (cpuSize == SIZE_WORD && req_lane != 2'b00)
                 || (|offset[31:ADDR_WIDTH+2]);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    index_d      = index_q;
    lane_d       = lane_q;
    size_d       = size_q;
    sext_d       = sext_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memWriteData = 32'h0;
    done         = 1'b0;
    addrError    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpuMemRead || cpuMemWrite) begin
          index_d = offset[ADDR_WIDTH+1:2];
          lane_d  = req_lane;
          size_d  = cpuSize;
          sext_d  = cpuSignExt;
          wdata_d = cpuWriteData;
          err_d   = req_err;
          if (req_err)                   state_d = DONE;
          else if (cpuMemRead)           state_d = LOAD;
          else if (cpuSize == SIZE_WORD) state_d = STORE;
          else                           state_d = RMW_RD;
        end
      end
      LOAD: begin
        memRead = 1'b1;
        rdata_d = extend_load(memReadData, lane_q, size_q, sext_q);
        state_d = DONE;
      end
      STORE: begin
        memWrite     = 1'b1;
        memWriteData = wdata_q;
        state_d      = DONE;
      end
      RMW_RD: begin
        memRead = 1'b1;
        word_d  = memReadData;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        memWrite     = 1'b1;
        memWriteData = merge_store(word_q, lane_q, size_q, wdata_q);
        state_d      = DONE;
      end
      DONE: begin
        done      = 1'b1;
        addrError = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
      index_q <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign memAddr     = index_q;
  assign cpuReadData = rdata_q;

endmodule
